// File: rtl/lsu_ctrl.sv
// Load/store control: aligns address, builds byte mask, shifts store data, extends load data.
// Latency: MEM_LAT+1 cycles accept-to-result for memory ops, 1 cycle for misaligned/non-memory ops.
// Backpressure: in_ready only in IDLE; out_ready low holds the result in DONE indefinitely.
module lsu_ctrl #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_load,
    input  logic        in_store,
    input  logic [2:0]  in_funct3,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        mem_read,
    output logic [63:0] mem_raddr,
    input  logic [63:0] mem_rdata,
    output logic        mem_write,
    output logic [63:0] mem_waddr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_rdata,
    output logic [4:0]  out_rd,
    output logic        out_misalign
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t      state, state_nx;
    logic        ld_q;
    logic [2:0]  f3_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [4:0]  rd_q;
    logic [3:0]  cnt_q;
    logic        mis_q;
    logic [63:0] rdata_q;

    logic        accept;
    logic        is_mem;
    logic        mis_in;
    logic [63:0] shifted;
    logic [63:0] ext;
    logic [7:0]  size_mask;
    logic [15:0] lane_mask;

    assign accept = in_valid && in_ready;
    assign is_mem = in_load || in_store;

    // Any address bit below the access size makes the operation misaligned.
    always_comb begin
        mis_in = 1'b0;
        case (in_funct3[1:0])
            2'd0:    mis_in = 1'b0;
            2'd1:    mis_in = in_addr[0];
            2'd2:    mis_in = |in_addr[1:0];
            default: mis_in = |in_addr[2:0];
        endcase
    end

    always_comb begin
        shifted = mem_rdata >> {addr_q[2:0], 3'b000};
        ext     = shifted;
        case (f3_q[1:0])
            2'd0:    ext = f3_q[2] ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
            2'd1:    ext = f3_q[2] ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            2'd2:    ext = f3_q[2] ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            default: ext = shifted;
        endcase
    end

    always_comb begin
        size_mask = 8'hFF;
        case (f3_q[1:0])
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
        lane_mask = {8'd0, size_mask} << addr_q[2:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_raddr = 64'd0;
        mem_waddr = 64'd0;
        mem_wdata = 64'd0;
        mem_wmask = 8'd0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nx = (mis_in || !is_mem) ? DONE : ACCESS;
            end
            ACCESS: begin
                mem_raddr = {addr_q[63:3], 3'b000};
                mem_waddr = {addr_q[63:3], 3'b000};
                if (ld_q) begin
                    mem_read = 1'b1;
                end else begin
                    // The memory model writes on every evaluation: strobe only on the first cycle.
                    mem_write = (cnt_q == LAT_M1);
                    mem_wmask = lane_mask[7:0];
                    mem_wdata = wdata_q << {addr_q[2:0], 3'b000};
                end
                if (cnt_q == 4'd0)
                    state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            rd_q    <= 5'd0;
            cnt_q   <= 4'd0;
            mis_q   <= 1'b0;
            rdata_q <= 64'd0;
        end else if (accept) begin
            ld_q    <= in_load;
            f3_q    <= in_funct3;
            addr_q  <= in_addr;
            wdata_q <= in_wdata;
            rd_q    <= in_rd;
            cnt_q   <= LAT_M1;
            mis_q   <= is_mem && mis_in;
            rdata_q <= 64'd0;
        end else if (state == ACCESS) begin
            if (cnt_q != 4'd0)
                cnt_q <= cnt_q - 4'd1;
            else if (ld_q)
                rdata_q <= ext;
        end
    end

    assign out_rdata    = rdata_q;
    assign out_rd       = rd_q;
    assign out_misalign = mis_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: scoreboard-checked results plus inline strobe/latency checks.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_valid4;
    logic        in_load, in_store;
    logic [2:0]  in_funct3;
    logic [63:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic [63:0] mem_rdata;
    logic        out_ready;

    logic        in_ready, mem_read, mem_write, out_valid, out_misalign;
    logic [63:0] mem_raddr, mem_waddr, mem_wdata, out_rdata;
    logic [7:0]  mem_wmask;
    logic [4:0]  out_rd;

    logic        in_ready4, mem_read4, mem_write4, out_valid4, out_misalign4;
    logic [63:0] mem_raddr4, mem_waddr4, mem_wdata4, out_rdata4;
    logic [7:0]  mem_wmask4;
    logic [4:0]  out_rd4;

    typedef struct {
        logic [63:0] rdata;
        logic [4:0]  rd;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.MEM_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_load(in_load), .in_store(in_store), .in_funct3(in_funct3),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .mem_read(mem_read), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_write(mem_write), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .out_valid(out_valid), .out_ready(out_ready),
        .out_rdata(out_rdata), .out_rd(out_rd), .out_misalign(out_misalign)
    );

    lsu_ctrl #(.MEM_LAT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_load(in_load), .in_store(in_store), .in_funct3(in_funct3),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .mem_read(mem_read4), .mem_raddr(mem_raddr4), .mem_rdata(mem_rdata),
        .mem_write(mem_write4), .mem_waddr(mem_waddr4), .mem_wdata(mem_wdata4),
        .mem_wmask(mem_wmask4), .out_valid(out_valid4), .out_ready(out_ready),
        .out_rdata(out_rdata4), .out_rd(out_rd4), .out_misalign(out_misalign4)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted result from the MEM_LAT=1 unit is matched against the queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_result", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_rdata", out_rdata, e.rdata);
                chk("sb_rd", {59'd0, out_rd}, {59'd0, e.rd});
                chk("sb_misalign", {63'd0, out_misalign}, {63'd0, e.mis});
            end
        end
    end

    task automatic scramble();
        in_load   = 1'($urandom);
        in_store  = 1'($urandom);
        in_funct3 = 3'($urandom);
        in_addr   = {$urandom, $urandom};
        in_wdata  = {$urandom, $urandom};
        in_rd     = 5'($urandom);
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rd);
        in_load = ld; in_store = st; in_funct3 = f3;
        in_addr = addr; in_wdata = wd; in_rd = rd;
    endtask

    // Issue one operation on the MEM_LAT=1 unit; called at posedge+1.
    task automatic do_op(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rd,
                         input logic [63:0] mrd, input logic [63:0] exp_rdata, input logic exp_mis,
                         input int exp_lat, input int exp_nr, input int exp_nw,
                         input logic [63:0] exp_ma, input logic [63:0] exp_wd, input logic [7:0] exp_mk);
        exp_t e;
        int nr = 0, nw = 0, lat = 0;
        chk({nm, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        drive(ld, st, f3, addr, wd, rd);
        mem_rdata = mrd;
        in_valid = 1'b1;
        e.rdata = exp_rdata; e.rd = rd; e.mis = exp_mis;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (mem_read) begin
                nr++;
                chk({nm, "_raddr"}, mem_raddr, exp_ma);
            end
            if (mem_write) begin
                nw++;
                chk({nm, "_waddr"}, mem_waddr, exp_ma);
                chk({nm, "_wdata"}, mem_wdata, exp_wd);
                chk({nm, "_wmask"}, {56'd0, mem_wmask}, {56'd0, exp_mk});
            end
            if (out_valid) begin
                lat = cyc;
                break;
            end
        end
        chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_reads"}, 64'(nr), 64'(exp_nr));
        chk({nm, "_writes"}, 64'(nw), 64'(exp_nw));
        @(posedge clk); #1;
    endtask

    initial begin
        int nw, lat, nr;
        rst_n = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1;
        mem_rdata = 64'd0;
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_mem_read", {63'd0, mem_read}, 64'd0);
        chk("rst_mem_write", {63'd0, mem_write}, 64'd0);
        chk("rst_out_rdata", out_rdata, 64'd0);
        chk("rst_out_misalign", {63'd0, out_misalign}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        //     name     ld    st    f3    addr            wdata                 rd     mem_rdata             exp_rdata              mis lat nr nw exp_memaddr     exp_wdata             mask
        do_op("ld",     1'b1, 1'b0, 3'd3, 64'h8000_0010, 64'd0,                5'd7,  64'h1122334455667788, 64'h1122334455667788, 0, 2, 1, 0, 64'h8000_0010, 64'd0, 8'h00);
        do_op("lb",     1'b1, 1'b0, 3'd0, 64'h8000_0003, 64'd0,                5'd3,  64'h00000000F0000000, 64'hFFFFFFFFFFFFFFF0, 0, 2, 1, 0, 64'h8000_0000, 64'd0, 8'h00);
        do_op("lbu",    1'b1, 1'b0, 3'd4, 64'h8000_0003, 64'd0,                5'd4,  64'h00000000F0000000, 64'h00000000000000F0, 0, 2, 1, 0, 64'h8000_0000, 64'd0, 8'h00);
        do_op("sh",     1'b0, 1'b1, 3'd1, 64'h8000_0006, 64'h000000000000ABCD, 5'd5,  64'hFFFFFFFFFFFFFFFF, 64'd0,                0, 2, 0, 1, 64'h8000_0000, 64'hABCD000000000000, 8'hC0);
        do_op("lw_mis", 1'b1, 1'b0, 3'd2, 64'h8000_0002, 64'd0,                5'd9,  64'h1234567812345678, 64'd0,                1, 1, 0, 0, 64'd0,         64'd0, 8'h00);
        do_op("lh",     1'b1, 1'b0, 3'd1, 64'h8000_000A, 64'd0,                5'd10, 64'h000000009ABC0000, 64'hFFFFFFFFFFFF9ABC, 0, 2, 1, 0, 64'h8000_0008, 64'd0, 8'h00);
        do_op("lwu",    1'b1, 1'b0, 3'd6, 64'h8000_0004, 64'd0,                5'd11, 64'h8765432100000000, 64'h0000000087654321, 0, 2, 1, 0, 64'h8000_0000, 64'd0, 8'h00);
        do_op("lw",     1'b1, 1'b0, 3'd2, 64'h8000_0004, 64'd0,                5'd12, 64'h8765432100000000, 64'hFFFFFFFF87654321, 0, 2, 1, 0, 64'h8000_0000, 64'd0, 8'h00);
        do_op("f3_7",   1'b1, 1'b0, 3'd7, 64'h8000_0008, 64'd0,                5'd13, 64'hDEADBEEF00000000, 64'hDEADBEEF00000000, 0, 2, 1, 0, 64'h8000_0008, 64'd0, 8'h00);
        do_op("nonmem", 1'b0, 1'b0, 3'd3, 64'h8000_0008, 64'd0,                5'd14, 64'h5555555555555555, 64'd0,                0, 1, 0, 0, 64'd0,         64'd0, 8'h00);
        do_op("ld_st",  1'b1, 1'b1, 3'd3, 64'h8000_0018, 64'h1111111111111111, 5'd15, 64'h0F0E0D0C0B0A0908, 64'h0F0E0D0C0B0A0908, 0, 2, 1, 0, 64'h8000_0018, 64'd0, 8'h00);
        do_op("sd",     1'b0, 1'b1, 3'd3, 64'h8000_0008, 64'h0102030405060708, 5'd16, 64'd0,                64'd0,                0, 2, 0, 1, 64'h8000_0008, 64'h0102030405060708, 8'hFF);
        do_op("sb",     1'b0, 1'b1, 3'd0, 64'h8000_0005, 64'h00000000001234EE, 5'd17, 64'd0,                64'd0,                0, 2, 0, 1, 64'h8000_0000, 64'h1234EE0000000000, 8'h20);
        do_op("sd_mis", 1'b0, 1'b1, 3'd3, 64'h8000_0004, 64'h0102030405060708, 5'd18, 64'd0,                64'd0,                1, 1, 0, 0, 64'd0,         64'd0, 8'h00);

        // MEM_LAT=4 store: single write strobe, result in cycle 5.
        drive(1'b0, 1'b1, 3'd1, 64'h8000_0006, 64'h000000000000ABCD, 5'd21);
        in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        scramble();
        nw = 0; lat = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (mem_write4) begin
                nw++;
                chk("sh4_waddr", mem_waddr4, 64'h8000_0000);
                chk("sh4_wdata", mem_wdata4, 64'hABCD000000000000);
                chk("sh4_wmask", {56'd0, mem_wmask4}, 64'hC0);
            end
            if (out_valid4) begin
                lat = cyc;
                break;
            end
        end
        chk("sh4_writes", 64'(nw), 64'd1);
        chk("sh4_latency", 64'(lat), 64'd5);
        chk("sh4_out_rd", {59'd0, out_rd4}, 64'd21);
        chk("sh4_out_rdata", out_rdata4, 64'd0);
        @(posedge clk); #1;

        // Stall: result held with out_ready low.
        out_ready = 1'b0;
        begin
            exp_t e;
            e.rdata = 64'hCAFEF00DDEADBEEF; e.rd = 5'd22; e.mis = 1'b0;
            sb.push_back(e);
        end
        drive(1'b1, 1'b0, 3'd3, 64'h8000_0020, 64'd0, 5'd22);
        mem_rdata = 64'hCAFEF00DDEADBEEF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        lat = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = cyc;
                break;
            end
        end
        chk("stall_latency", 64'(lat), 64'd2);
        mem_rdata = 64'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_out_rdata", out_rdata, 64'hCAFEF00DDEADBEEF);
            chk("stall_out_rd", {59'd0, out_rd}, 64'd22);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Reset during ACCESS of a load on the MEM_LAT=1 unit.
        drive(1'b1, 1'b0, 3'd3, 64'h8000_0028, 64'd0, 5'd23);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("abort_ld_in_access", {63'd0, mem_read}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_ld_mem_read", {63'd0, mem_read}, 64'd0);
        chk("abort_ld_in_ready", {63'd0, in_ready}, 64'd1);
        chk("abort_ld_out_rd", {59'd0, out_rd}, 64'd0);
        chk("abort_ld_out_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Reset during ACCESS of a store on the MEM_LAT=4 unit.
        drive(1'b0, 1'b1, 3'd3, 64'h8000_0030, 64'h0123456789ABCDEF, 5'd24);
        in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        chk("abort_st_first_write", {63'd0, mem_write4}, 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_st_in_ready", {63'd0, in_ready4}, 64'd1);
        chk("abort_st_mem_write", {63'd0, mem_write4}, 64'd0);
        chk("abort_st_wmask", {56'd0, mem_wmask4}, 64'd0);
        chk("abort_st_out_rd", {59'd0, out_rd4}, 64'd0);
        chk("abort_st_out_valid", {63'd0, out_valid4}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        nw = 0; nr = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_write4 || mem_write) nw++;
            if (out_valid4 || out_valid || mem_read) nr++;
        end
        chk("abort_no_write_after", 64'(nw), 64'd0);
        chk("abort_no_result_after", 64'(nr), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store control unit between the execute stage and the DPI-backed memory model in the NPC core. It accepts one memory operation per transaction through a valid/ready handshake. For each operation it aligns the address, builds the byte mask, shifts store data, sequences the memory read/write strobes, and extracts and sign- or zero-extends load data. Results go to writeback through a second valid/ready handshake.

## Interface
- MEM_LAT, 1, cycles the memory read strobe is held before `mem_rdata` is sampled; legal range 1..15.
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  execute stage presents an operation.
- in_ready  out  1  unit can accept an operation; high only in IDLE.
- in_load  in  1  operation is a load.
- in_store  in  1  operation is a store. `in_load` and `in_store` both high is illegal; the unit treats it as a load.
- in_funct3  in  3  RISC-V funct3 encoding:
  - 0 = b, 1 = h, 2 = w, 3 = d (signed sizes);
  - 4 = bu, 5 = hu, 6 = wu (unsigned sizes);
  - 7 is treated as d.
- in_addr  in  64  effective byte address.
- in_wdata  in  64  store data, least-significant bytes significant.
- in_rd  in  5  destination register tag, passed through.
- mem_read  out  1  read strobe to memory.
- mem_raddr  out  64  read address; low three bits always 0.
- mem_rdata  in  64  read data, combinationally valid while `mem_read` is high.
- mem_write  out  1  write strobe to memory.
- mem_waddr  out  64  write address; low three bits always 0.
- mem_wdata  out  64  write data, lane-shifted.
- mem_wmask  out  8  byte-enable mask.
- out_valid  out  1  result available to writeback.
- out_ready  in  1  writeback accepts the result.
- out_rdata  out  64  extended load data; 0 for stores, non-memory operations and faults.
- out_rd  out  5  latched `in_rd`.
- out_misalign  out  1  operation was misaligned; no memory access was made.

## Operation
- The state machine has three states: IDLE, ACCESS and DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid` && `in_ready`, latch load, store, funct3, addr, wdata and rd.
  - Size in bytes: S = 1 << funct3[1:0].
  - Misaligned when `addr[2:0]` mod S ≠ 0, i.e. any low bit within the size is set.
  - Go to DONE directly when the operation is misaligned or is neither load nor store. Otherwise go to ACCESS and load the wait counter with MEM_LAT−1.
- ACCESS:
  - `mem_raddr` = `mem_waddr` = {addr[63:3], 3'b000}.
  - Load:
    - `mem_read` = 1 in every ACCESS cycle.
    - In the cycle the counter is 0, capture `mem_rdata` into the result register and go to DONE. Otherwise decrement the counter.
  - Store:
    - `mem_write` = 1 only in the first ACCESS cycle. The memory model performs a write on every evaluation, so a second assertion is forbidden.
    - Go to DONE when the counter reaches 0, so a store takes the same ACCESS duration as a load.
    - `mem_wmask` = ((1 << S) − 1) << addr[2:0], truncated to 8 bits.
    - `mem_wdata` = wdata << (8·addr[2:0]).
- Load extraction: shift the captured data right by 8·addr[2:0] and keep the low 8·S bits.
  - funct3[2] = 0: sign-extend from bit 8·S−1.
  - funct3[2] = 1: zero-extend.
  - d ignores funct3[2].
- DONE:
  - `out_valid` = 1.
  - `out_rdata`, `out_rd` and `out_misalign` are held stable until `out_valid` && `out_ready`, then go to IDLE.
  - No new operation is accepted in the handshake cycle.
- Outside ACCESS, `mem_read`, `mem_write` and `mem_wmask` are 0. Address and data outputs are then don't-care and are driven 0.

## Timing
- Reset (`rst_n` low, asynchronous):
  - state IDLE, counter 0;
  - `in_ready` = 1;
  - `out_valid`, `out_misalign`, `out_rdata`, `out_rd` = 0;
  - `mem_read` and `mem_write` = 0 combinationally from the state.
- Reset mid-ACCESS aborts the operation. No strobe is raised afterwards, and no result is produced.
- Accept edge is cycle 0. ACCESS occupies cycles 1..MEM_LAT. `out_valid` first rises in cycle MEM_LAT+1.
- Misaligned and non-memory operations produce `out_valid` in cycle 1.
- Minimum spacing between accepts is MEM_LAT+2 cycles; at MEM_LAT = 1 that is 3 cycles.
- `out_ready` low stalls in DONE indefinitely with outputs held. `in_ready` stays low during the stall.
- `in_*` inputs are sampled only on the accept edge. Changes afterwards have no effect.

## Test plan
- MEM_LAT = 1, ld at 0x80000010; memory returns 0x1122334455667788.
  - `mem_read` is high exactly in cycle 1.
  - `out_rdata` = 0x1122334455667788 in cycle 2.
  - `out_rd` matches the issued rd.
- lb at 0x80000003 with `mem_rdata` = 0x00000000F0000000 → `out_rdata` = 0xFFFFFFFFFFFFFFF0.
- Same stimulus as lbu → `out_rdata` = 0x00000000000000F0.
- sh at 0x80000006, `in_wdata` = 0xABCD:
  - `mem_waddr` = 0x80000000;
  - `mem_wmask` = 0xC0;
  - `mem_wdata` = 0xABCD000000000000;
  - `mem_write` is high for exactly one cycle, including with MEM_LAT = 4.
- lw at 0x80000002:
  - `out_misalign` = 1 and `out_rdata` = 0 in cycle 1;
  - `mem_read` and `mem_write` are never asserted.
- Stall and reset:
  - Hold `out_ready` = 0 for 5 cycles: outputs stay stable and `in_ready` stays 0.
  - Then assert `rst_n` low mid-ACCESS of a second operation: all outputs return to reset values immediately, and no write strobe appears.
